mem_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 32-entry × 8-bit register array among up to four requesters. Each requester raises a request. The block grants one requester per cycle and performs that requester's read or write on the array, then returns read data with a requester tag. It sits between the per-requester front ends and the shared storage array, and is the only block that drives the array's address, data and write strobe. Optional locked bursts let one requester hold the array for several consecutive cycles.

---
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and sequencer sharing one register array among up to four
// requesters, with optional locked bursts and tagged read responses.
module mem_arbiter #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 32,
    parameter int AWIDTH   = 5,
    parameter int MAXBURST = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          lock,
    input  logic [NREQ-1:0]          we,
    input  logic [NREQ*AWIDTH-1:0]   addr,
    input  logic [NREQ*WIDTH-1:0]    wdata,
    output logic [NREQ-1:0]          gnt,
    output logic                     rvalid,
    output logic [WIDTH-1:0]         rdata,
    output logic [1:0]               rid
);

    localparam int CW = (MAXBURST > 1) ? $clog2(MAXBURST) : 1;
    localparam logic [CW-1:0]     BLAST   = CW'(MAXBURST - 1);
    localparam logic [1:0]        LASTREQ = 2'(NREQ - 1);
    localparam logic [AWIDTH:0]   DEPTH_W = (AWIDTH + 1)'(DEPTH);
    localparam logic [NREQ-1:0]   ONE_HOT = NREQ'(1);

    typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t               state_r, state_next_s;
    logic [1:0]           w_r, w_next_s;
    logic [1:0]           ptr_r, ptr_next_s, ptr_inc_s;
    logic [CW-1:0]        cnt_r, cnt_next_s;
    logic [NREQ-1:0]      gnt_r, gnt_next_s;
    logic                 rst_done_r;
    logic                 acc_s, rd_s, wr_s, in_range_s;
    logic [AWIDTH-1:0]    addr_w_s;
    logic [WIDTH-1:0]     wdata_w_s;
    logic [AWIDTH-1:0]    addr_a [NREQ];
    logic [WIDTH-1:0]     wdata_a [NREQ];
    logic                 rvalid_r;
    logic [WIDTH-1:0]     rdata_r;
    logic [1:0]           rid_r;
    logic [WIDTH-1:0]     mem [DEPTH];

    // First requester at or after position p, wrapping modulo NREQ.
    function automatic logic [1:0] pick(input logic [NREQ-1:0] r, input logic [1:0] p);
        logic [1:0] res;
        logic       found;
        int         j;
        res   = p;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(p) + i) % NREQ;
            if (!found && r[j]) begin
                res   = 2'(j);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return res;
    endfunction

    // Unpack the per-requester address and data buses.
    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            addr_a[k]  = addr[k*AWIDTH +: AWIDTH];
            wdata_a[k] = wdata[k*WIDTH +: WIDTH];
        end
    end

    // Access decode for the requester currently holding the grant.
    always_comb begin
        addr_w_s   = addr_a[w_r];
        wdata_w_s  = wdata_a[w_r];
        in_range_s = ({1'b0, addr_w_s} < DEPTH_W);
        acc_s      = (state_r == GRANT) && req[w_r];
        rd_s       = acc_s && !we[w_r];
        wr_s       = acc_s && we[w_r] && in_range_s;
        ptr_inc_s  = (w_r == LASTREQ) ? 2'd0 : w_r + 2'd1;
    end

    // Next-state, burst and arbitration logic.
    always_comb begin
        state_next_s = state_r;
        w_next_s     = w_r;
        ptr_next_s   = ptr_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (rst_done_r && (|req)) begin
                    state_next_s = GRANT;
                    w_next_s     = pick(req, ptr_r);
                    cnt_next_s   = {CW{1'b0}};
                end else begin
                    state_next_s = IDLE;
                end
            end
            GRANT: begin
                if (req[w_r] && lock[w_r] && (cnt_r < BLAST)) begin
                    cnt_next_s = cnt_r + CW'(1);
                end else begin
                    // Burst over: the winner drops to lowest priority for the re-arbitration.
                    ptr_next_s = ptr_inc_s;
                    cnt_next_s = {CW{1'b0}};
                    if (|req) begin
                        w_next_s = pick(req, ptr_inc_s);
                    end else begin
                        state_next_s = IDLE;
                    end
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
        if (state_next_s == GRANT) begin
            gnt_next_s = ONE_HOT << w_next_s;
        end else begin
            gnt_next_s = {NREQ{1'b0}};
        end
    end

    // Control state, grant and read-response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            w_r        <= 2'd0;
            ptr_r      <= 2'd0;
            cnt_r      <= {CW{1'b0}};
            gnt_r      <= {NREQ{1'b0}};
            rst_done_r <= 1'b0;
            rvalid_r   <= 1'b0;
            rdata_r    <= {WIDTH{1'b0}};
            rid_r      <= 2'd0;
        end else begin
            state_r    <= state_next_s;
            w_r        <= w_next_s;
            ptr_r      <= ptr_next_s;
            cnt_r      <= cnt_next_s;
            gnt_r      <= gnt_next_s;
            rst_done_r <= 1'b1;
            rvalid_r   <= rd_s;
            if (rd_s) begin
                rdata_r <= in_range_s ? mem[addr_w_s] : {WIDTH{1'b0}};
                rid_r   <= w_r;
            end else begin
                rdata_r <= rdata_r;
                rid_r   <= rid_r;
            end
        end
    end

    // Storage array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem[addr_w_s] <= wdata_w_s;
        end
    end

    assign gnt    = gnt_r;
    assign rvalid = rvalid_r;
    assign rdata  = rdata_r;
    assign rid    = rid_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (DEPTH=20 to reach the out-of-range path).
module tb_mem_arbiter;

    localparam int NREQ = 4;
    localparam int WIDTH = 8;
    localparam int AWIDTH = 5;

    logic                   clk;
    logic                   rst_n;
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        lock;
    logic [NREQ-1:0]        we;
    logic [NREQ*AWIDTH-1:0] addr;
    logic [NREQ*WIDTH-1:0]  wdata;
    logic [NREQ-1:0]        gnt;
    logic                   rvalid;
    logic [WIDTH-1:0]       rdata;
    logic [1:0]             rid;

    int n_checks;
    int n_fail;

    mem_arbiter #(
        .NREQ(4), .WIDTH(8), .DEPTH(20), .AWIDTH(5), .MAXBURST(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .we(we),
        .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid),
        .rdata(rdata), .rid(rid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_port(input int k, input logic w, input logic [4:0] a, input logic [7:0] d);
        we[k]                  = w;
        addr[k*AWIDTH +: AWIDTH] = a;
        wdata[k*WIDTH +: WIDTH]  = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        lock  = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic write_mem(input int k, input logic [4:0] a, input logic [7:0] d);
        set_port(k, 1'b1, a, d);
        req[k] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        lock  = 4'b0000;
        we    = 4'b0000;
        addr  = {NREQ*AWIDTH{1'b0}};
        wdata = {NREQ*WIDTH{1'b0}};
        repeat (3) @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0000 || rvalid !== 1'b0 || rdata !== 8'h00 || rid !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_vals: gnt=%b rvalid=%b rdata=%h rid=%0d, want 0000 0 00 0", gnt, rvalid, rdata, rid);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0000 || rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: gnt=%b rvalid=%b, want 0000 0", gnt, rvalid);
        end
    endtask

    task automatic test_write_read();
        set_port(0, 1'b1, 5'd3, 8'hA5);
        req = 4'b0001;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL wr_gnt: gnt=%b, want 0001", gnt);
        end
        @(negedge clk);
        req = 4'b0000;
        n_checks++;
        if (rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_no_rvalid: rvalid=%b, want 0", rvalid);
        end
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL wr_idle: gnt=%b, want 0000", gnt);
        end
        set_port(0, 1'b0, 5'd3, 8'h00);
        req = 4'b0001;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0001 || rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_gnt: gnt=%b rvalid=%b, want 0001 0", gnt, rvalid);
        end
        @(negedge clk);
        req = 4'b0000;
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== 8'hA5 || rid !== 2'd0) begin
            n_fail++;
            $display("FAIL rd_data: rvalid=%b rdata=%h rid=%0d, want 1 a5 0", rvalid, rdata, rid);
        end
        @(negedge clk);
        n_checks++;
        if (rvalid !== 1'b0 || rdata !== 8'hA5 || gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL rd_hold: rvalid=%b rdata=%h gnt=%b, want 0 a5 0000", rvalid, rdata, gnt);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt;
        logic [1:0] exp_rid;
        rst_n = 1'b0;
        for (int k = 0; k < NREQ; k++) set_port(k, 1'b0, 5'd0, 8'h00);
        req = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL rr_first_edge: gnt=%b, want 0000", gnt);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            exp_gnt = 4'b0001 << (i % 4);
            n_checks++;
            if (gnt !== exp_gnt) begin
                n_fail++;
                $display("FAIL rr_gnt[%0d]: gnt=%b, want %b", i, gnt, exp_gnt);
            end
            if (i > 0) begin
                exp_rid = 2'((i - 1) % 4);
                n_checks++;
                if (rvalid !== 1'b1 || rid !== exp_rid) begin
                    n_fail++;
                    $display("FAIL rr_rid[%0d]: rvalid=%b rid=%0d, want 1 %0d", i, rvalid, rid, exp_rid);
                end
            end
        end
        req = 4'b0000;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_burst();
        do_reset();
        req  = 4'b0110;
        lock = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (gnt !== 4'b0010) begin
                n_fail++;
                $display("FAIL burst_hold[%0d]: gnt=%b, want 0010", i, gnt);
            end
        end
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0100) begin
            n_fail++;
            $display("FAIL burst_end: gnt=%b, want 0100", gnt);
        end
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL burst_rotate: gnt=%b, want 0010", gnt);
        end
        req  = 4'b0000;
        lock = 4'b0000;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_withdraw();
        do_reset();
        write_mem(0, 5'd7, 8'h3C);
        set_port(3, 1'b1, 5'd7, 8'hFF);
        req = 4'b1000;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b1000) begin
            n_fail++;
            $display("FAIL wd_gnt3: gnt=%b, want 1000", gnt);
        end
        set_port(1, 1'b0, 5'd7, 8'h00);
        req = 4'b0010;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0010 || rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_next: gnt=%b rvalid=%b, want 0010 0", gnt, rvalid);
        end
        @(negedge clk);
        req = 4'b0000;
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== 8'h3C || rid !== 2'd1) begin
            n_fail++;
            $display("FAIL wd_unchanged: rvalid=%b rdata=%h rid=%0d, want 1 3c 1", rvalid, rdata, rid);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_out_of_range();
        set_port(2, 1'b0, 5'd25, 8'h00);
        req = 4'b0100;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0100) begin
            n_fail++;
            $display("FAIL oor_gnt: gnt=%b, want 0100", gnt);
        end
        @(negedge clk);
        req = 4'b0000;
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== 8'h00 || rid !== 2'd2) begin
            n_fail++;
            $display("FAIL oor_read: rvalid=%b rdata=%h rid=%0d, want 1 00 2", rvalid, rdata, rid);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        set_port(0, 1'b0, 5'd3, 8'h00);
        req = 4'b0001;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL mr_gnt: gnt=%b, want 0001", gnt);
        end
        rst_n = 1'b0;
        req   = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (rvalid !== 1'b0 || gnt !== 4'b0000 || rdata !== 8'h00) begin
                n_fail++;
                $display("FAIL mr_drop[%0d]: rvalid=%b gnt=%b rdata=%h, want 0 0000 00", i, rvalid, gnt, rdata);
            end
            if (i == 1) rst_n = 1'b1;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_write_read();
        test_round_robin();
        test_burst();
        test_withdraw();
        test_out_of_range();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
